// File: rtl/instr_fetch_if.sv
// Instruction-memory read port: one-cycle request pulse, single response per request.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_valid;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem read, one-cycle presentation
// to the decoder with stall hold and redirect flush.
//
// state | meaning
// IDLE  | first cycle after reset release
// FETCH | imem_req asserted for the current PC
// WAIT  | request outstanding, waiting for imem_valid
// HOLD  | word captured while stalled, waiting for stall release
// DROP  | stale response pending after a redirect, discard it
module instr_fetch #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  instr_fetch_if.master     imem,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DROP  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_pc_out, w_pc_out_nxt;
  logic [31:0]       r_instr, w_instr_nxt;
  logic              r_valid, w_valid_nxt;
  logic [31:0]       r_hold, w_hold_nxt;
  logic              w_inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_pc_out <= '0;
      r_instr  <= NOP_INSTR;
      r_valid  <= 1'b0;
      r_hold   <= NOP_INSTR;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_instr  <= w_instr_nxt;
      r_valid  <= w_valid_nxt;
      r_hold   <= w_hold_nxt;
    end
  end

  // A request issued in FETCH is already in flight, so a redirect there must drop its response too.
  assign w_inflight = (r_state == FETCH) || (r_state == WAIT) || (r_state == DROP);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_pc_out_nxt = r_pc_out;
    w_hold_nxt   = r_hold;
    w_instr_nxt  = stall ? r_instr : NOP_INSTR;
    w_valid_nxt  = stall ? r_valid : 1'b0;

    if (redirect) begin
      w_pc_nxt    = redirect_pc & ~ADDR_W'(3);
      w_instr_nxt = NOP_INSTR;
      w_valid_nxt = 1'b0;
      w_hold_nxt  = NOP_INSTR;
      w_state_nxt = (w_inflight && !imem.imem_valid) ? DROP : FETCH;
    end else begin
      case (r_state)
        IDLE:  w_state_nxt = FETCH;
        FETCH: w_state_nxt = WAIT;
        WAIT: begin
          if (imem.imem_valid) begin
            if (stall) begin
              w_hold_nxt  = imem.imem_rdata;
              w_state_nxt = HOLD;
            end else begin
              w_instr_nxt  = imem.imem_rdata;
              w_valid_nxt  = 1'b1;
              w_pc_out_nxt = r_pc;
              w_pc_nxt     = r_pc + ADDR_W'(4);
              w_state_nxt  = FETCH;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            w_instr_nxt  = r_hold;
            w_valid_nxt  = 1'b1;
            w_pc_out_nxt = r_pc;
            w_pc_nxt     = r_pc + ADDR_W'(4);
            w_state_nxt  = FETCH;
          end
        end
        DROP: begin
          if (imem.imem_valid) w_state_nxt = FETCH;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign imem.imem_req  = (r_state == FETCH);
  assign imem.imem_addr = r_pc;
  assign instr_out      = r_instr;
  assign instr_valid    = r_valid;
  assign pc_out         = r_pc_out;

endmodule
